// File: rtl/quiz_pkg.sv
// Shared encodings and helpers for the quiz round controller.
package quiz_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StLocked  = 3'd2,
        StTimeout = 3'd3
    } quiz_state_e;

    localparam logic [3:0] PlayerNone = 4'd0;
    localparam logic [3:0] Player1    = 4'd1;
    localparam logic [3:0] Player2    = 4'd2;
    localparam logic [3:0] Player3    = 4'd3;
    localparam logic [3:0] Player4    = 4'd4;

    localparam logic [3:0] MaxScore = 4'd9;

    // Out-of-range player counts are pulled into 2..4.
    function automatic logic [2:0] clamp_players(input logic [3:0] n);
        logic [2:0] r;
        if (n < 4'd2) begin
            r = 3'd2;
        end else if (n > 4'd4) begin
            r = 3'd4;
        end else begin
            r = n[2:0];
        end
        return r;
    endfunction

    // One bit per seated player: bit i is set when i < n.
    function automatic logic [3:0] seat_mask(input logic [2:0] n);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (3'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/quiz_bcd_downcnt.sv
// Loadable single-digit BCD down-counter; expire flags the tick that reaches 0.
module quiz_bcd_downcnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       tick_i,
    output logic [3:0] count_o,
    output logic       expire_o
);

    logic [3:0] count_q, count_d;

    assign count_o  = count_q;
    assign expire_o = tick_i && (count_q == 4'd1);

    // Load wins over tick; the count rests at 0 once reached.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round controller: buzz arbitration, answer/reply windows, lockouts and scores.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int unsigned T_ANSWER = 9,
    parameter int unsigned T_REPLY  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        host_start,
    input  logic [3:0]  num_players,
    input  logic [3:0]  buzz,
    input  logic        judge_ok,
    input  logic        judge_bad,
    output logic        showready,
    output logic [3:0]  countdown,
    output logic [3:0]  winner,
    output logic [3:0]  excluded,
    output logic [15:0] score,
    output logic [2:0]  state
);

    localparam logic [3:0] TAnswer = 4'(T_ANSWER);
    localparam logic [3:0] TReply  = 4'(T_REPLY);

    quiz_state_e state_q, state_d;
    logic [3:0]  winner_q, winner_d;
    logic [3:0]  excluded_q, excluded_d;
    logic [15:0] score_q, score_d;
    logic        showready_q, showready_d;

    logic        cnt_load;
    logic [3:0]  cnt_val;
    logic        cnt_tick;
    logic        cnt_expire;
    logic [3:0]  valid;
    logic [3:0]  pick;
    logic [3:0]  drop;

    assign cnt_tick = tick_1hz && ((state_q == StArmed) || (state_q == StLocked));

    quiz_bcd_downcnt u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .tick_i     (cnt_tick),
        .count_o    (countdown),
        .expire_o   (cnt_expire)
    );

    // Next-state, window control, lockout and scoring decisions.
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        excluded_d = excluded_q;
        score_d    = score_q;
        cnt_load   = 1'b0;
        cnt_val    = TAnswer;

        // Lowest-index valid buzzer wins a tie.
        valid = buzz & ~excluded_q;
        if (valid[0]) begin
            pick = Player1;
        end else if (valid[1]) begin
            pick = Player2;
        end else if (valid[2]) begin
            pick = Player3;
        end else if (valid[3]) begin
            pick = Player4;
        end else begin
            pick = PlayerNone;
        end

        // Lockout mask if the current answerer gets thrown out.
        drop = excluded_q;
        for (int i = 0; i < 4; i++) begin
            if (winner_q == 4'(i + 1)) begin
                drop[i] = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (host_start) begin
                    // Fouls and empty seats are locked out for the whole round.
                    excluded_d = buzz | ~seat_mask(clamp_players(num_players));
                    winner_d   = PlayerNone;
                    cnt_load   = 1'b1;
                    cnt_val    = TAnswer;
                    state_d    = (&excluded_d) ? StTimeout : StArmed;
                end
            end
            StArmed: begin
                if (pick != PlayerNone) begin
                    winner_d = pick;
                    cnt_load = 1'b1;
                    cnt_val  = TReply;
                    state_d  = StLocked;
                end else if (cnt_expire) begin
                    winner_d = PlayerNone;
                    state_d  = StTimeout;
                end
            end
            StLocked: begin
                if (judge_ok) begin
                    for (int i = 0; i < 4; i++) begin
                        if ((winner_q == 4'(i + 1)) && (score_q[4*i +: 4] < MaxScore)) begin
                            score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                        end
                    end
                    state_d = StIdle;
                end else if (judge_bad || cnt_expire) begin
                    excluded_d = drop;
                    winner_d   = PlayerNone;
                    if (&drop) begin
                        state_d = StTimeout;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = TAnswer;
                        state_d  = StArmed;
                    end
                end
            end
            StTimeout: begin
                if (host_start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        showready_d = (state_d == StArmed) && (state_q != StArmed);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            winner_q    <= PlayerNone;
            excluded_q  <= 4'd0;
            score_q     <= 16'd0;
            showready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            excluded_q  <= excluded_d;
            score_q     <= score_d;
            showready_q <= showready_d;
        end
    end

    assign showready = showready_q;
    assign winner    = winner_q;
    assign excluded  = excluded_q;
    assign score     = score_q;
    assign state     = state_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl with default window lengths (9 s / 5 s).
module tb_quiz_round_ctrl;

    localparam int SIdle = 0, SArmed = 1, SLocked = 2, STimeout = 3;
    localparam int SelState = 0, SelWinner = 1, SelCd = 2, SelExcl = 3,
                   SelScore = 4, SelShow = 5, SelExclLo = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        host_start = 1'b0;
    logic [3:0]  num_players = 4'd4;
    logic [3:0]  buzz = 4'd0;
    logic        judge_ok = 1'b0;
    logic        judge_bad = 1'b0;
    logic        showready;
    logic [3:0]  countdown;
    logic [3:0]  winner;
    logic [3:0]  excluded;
    logic [15:0] score;
    logic [2:0]  state;

    quiz_round_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .host_start  (host_start),
        .num_players (num_players),
        .buzz        (buzz),
        .judge_ok    (judge_ok),
        .judge_bad   (judge_bad),
        .showready   (showready),
        .countdown   (countdown),
        .winner      (winner),
        .excluded    (excluded),
        .score       (score),
        .state       (state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb_q[$];
    logic [3:0] m_score[4];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SelState:  return {13'd0, state};
            SelWinner: return {12'd0, winner};
            SelCd:     return {12'd0, countdown};
            SelExcl:   return {12'd0, excluded};
            SelScore:  return score;
            SelShow:   return {15'd0, showready};
            default:   return {14'd0, excluded[1:0]};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = 16'(val);
        sb_q.push_back(e);
    endtask

    task automatic drain();
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic expect_core(input string tag, input int st, input int win, input int cd);
        push({tag, ".state"}, SelState, st);
        push({tag, ".winner"}, SelWinner, win);
        if (cd >= 0) push({tag, ".cd"}, SelCd, cd);
        drain();
    endtask

    function automatic int model_score();
        return int'({m_score[3], m_score[2], m_score[1], m_score[0]});
    endfunction

    task automatic model_ok(input int p);
        if (m_score[p-1] < 4'd9) m_score[p-1] = m_score[p-1] + 4'd1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] n, input logic [3:0] b);
        num_players = n;
        buzz = b;
        host_start = 1'b1;
        cyc();
        host_start = 1'b0;
        buzz = 4'd0;
    endtask

    task automatic do_buzz(input logic [3:0] b);
        buzz = b;
        cyc();
        buzz = 4'd0;
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    task automatic judge(input logic ok, input logic nok);
        judge_ok = ok;
        judge_bad = nok;
        cyc();
        judge_ok = 1'b0;
        judge_bad = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_score[i] = 4'd0;

        // Reset values held while rst is low
        repeat (2) cyc();
        push("rst.excl", SelExcl, 0);
        push("rst.score", SelScore, 0);
        push("rst.show", SelShow, 0);
        expect_core("rst", SIdle, 0, 0);
        rst = 1'b1;
        cyc();

        // Four players, player 3 buzzes two cycles after start and is judged correct
        do_start(4'd4, 4'b0000);
        push("s1.excl", SelExcl, 0);
        push("s1.show", SelShow, 1);
        expect_core("s1.start", SArmed, 0, 9);
        cyc();
        push("s1.show0", SelShow, 0);
        drain();
        cyc();
        do_buzz(4'b0100);
        expect_core("s1.lock", SLocked, 3, 5);
        judge(1'b1, 1'b0);
        model_ok(3);
        push("s1.score", SelScore, model_score());
        expect_core("s1.ok", SIdle, 3, 5);

        // Three players: seat 4 locked out, simultaneous buzz goes to lowest index
        do_start(4'd3, 4'b0000);
        push("s2.excl", SelExcl, 4'b1000);
        drain();
        do_buzz(4'b1000);
        expect_core("s2.p4ign", SArmed, 0, 9);
        do_buzz(4'b1110);
        expect_core("s2.tie", SLocked, 2, 5);
        judge(1'b1, 1'b1);
        model_ok(2);
        push("s2.score", SelScore, model_score());
        expect_core("s2.okbad", SIdle, 2, -1);

        // Foul at start locks player 1 out
        do_start(4'd4, 4'b0001);
        push("s3.excl", SelExcl, 4'b0001);
        expect_core("s3.start", SArmed, 0, 9);
        do_buzz(4'b0001);
        expect_core("s3.foul", SArmed, 0, -1);
        do_buzz(4'b0011);
        expect_core("s3.lock", SLocked, 2, 5);
        judge(1'b0, 1'b1);
        push("s3.excl2", SelExcl, 4'b0011);
        push("s3.show", SelShow, 1);
        expect_core("s3.bad", SArmed, 0, 9);
        num_players = 4'd2;
        host_start = 1'b1;
        cyc();
        host_start = 1'b0;
        push("s3.hsign", SelExcl, 4'b0011);
        expect_core("s3.hs", SArmed, 0, -1);
        judge(1'b1, 1'b0);
        push("s3.jign", SelScore, model_score());
        drain();
        do_buzz(4'b1000);
        expect_core("s3.p4", SLocked, 4, 5);
        judge(1'b1, 1'b0);
        model_ok(4);
        push("s3.score", SelScore, model_score());
        drain();

        // Two players, both thrown out: reply window expires into timeout
        do_start(4'd2, 4'b0000);
        push("s4.excl", SelExcl, 4'b1100);
        drain();
        do_buzz(4'b0001);
        expect_core("s4.p1", SLocked, 1, 5);
        judge(1'b0, 1'b1);
        expect_core("s4.bad", SArmed, 0, 9);
        do_buzz(4'b0010);
        expect_core("s4.p2", SLocked, 2, 5);
        for (int k = 1; k <= 4; k++) begin
            do_tick();
            expect_core("s4.tick", SLocked, 2, 5 - k);
        end
        do_tick();
        push("s4.excllo", SelExclLo, 3);
        expect_core("s4.exp", STimeout, 0, 0);
        judge(1'b1, 1'b0);
        push("s4.jign", SelScore, model_score());
        drain();
        do_start(4'd4, 4'b0000);
        push("s4.show", SelShow, 0);
        expect_core("s4.clear", SIdle, 0, 0);

        // Answer window runs out with no buzz
        do_start(4'd4, 4'b0000);
        expect_core("s5.start", SArmed, 0, 9);
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            expect_core("s5.tick", SArmed, 0, 9 - k);
        end
        do_tick();
        expect_core("s5.exp", STimeout, 0, 0);
        do_start(4'd4, 4'b0000);
        expect_core("s5.clear", SIdle, 0, -1);

        // Buzz in the expiry cycle wins over expiry
        do_start(4'd4, 4'b0000);
        repeat (8) do_tick();
        expect_core("s5.last", SArmed, 0, 1);
        buzz = 4'b0010;
        tick_1hz = 1'b1;
        cyc();
        buzz = 4'd0;
        tick_1hz = 1'b0;
        expect_core("s5.race", SLocked, 2, 5);
        repeat (4) do_tick();
        // Judge pulse in the reply-expiry cycle wins over expiry
        judge_ok = 1'b1;
        tick_1hz = 1'b1;
        cyc();
        judge_ok = 1'b0;
        tick_1hz = 1'b0;
        model_ok(2);
        push("s5.jscore", SelScore, model_score());
        expect_core("s5.jrace", SIdle, 2, -1);

        // Everyone fouls at start: straight to timeout
        do_start(4'd2, 4'b0011);
        push("s6.excl", SelExcl, 4'b1111);
        expect_core("s6.allfoul", STimeout, 0, -1);
        do_start(4'd4, 4'b0000);
        expect_core("s6.clear", SIdle, 0, -1);

        // Player 1 score saturates at 9
        for (int r = 0; r < 10; r++) begin
            do_start(4'd4, 4'b0000);
            do_buzz(4'b0001);
            judge(1'b1, 1'b0);
            model_ok(1);
            push("sat.score", SelScore, model_score());
            push("sat.state", SelState, SIdle);
            drain();
        end

        // Player count clamping
        do_start(4'd0, 4'b0000);
        push("clamp.lo", SelExcl, 4'b1100);
        drain();
        do_buzz(4'b0001);
        judge(1'b1, 1'b0);
        do_start(4'd7, 4'b0000);
        push("clamp.hi", SelExcl, 4'b0000);
        drain();

        // Asynchronous reset while LOCKED abandons the round
        do_buzz(4'b0001);
        expect_core("rst2.pre", SLocked, 1, 5);
        rst = 1'b0;
        #1;
        push("rst2.excl", SelExcl, 0);
        push("rst2.score", SelScore, 0);
        push("rst2.show", SelShow, 0);
        expect_core("rst2", SIdle, 0, 0);
        judge_ok = 1'b1;
        cyc();
        judge_ok = 1'b0;
        rst = 1'b1;
        cyc();
        push("rst2.after", SelScore, 0);
        expect_core("rst2.after", SIdle, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/quiz_round_ctrl.md
QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

Interface
REQ-001 SHALL have parameter T_ANSWER, default 9, buzz-window length in seconds (1..9).
REQ-002 SHALL have parameter T_REPLY, default 5, reply-window length in seconds (1..9).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tick_1hz  input  1  one-clk pulse per second.
REQ-006 SHALL have port host_start  input  1  one-clk pulse, starts a round or clears a finished one.
REQ-007 SHALL have port num_players  input  4  player count, BCD 2..4.
REQ-008 SHALL have port buzz  input  4  synchronized buzzer levels; bit0 = player1, bit3 = player4.
REQ-009 SHALL have ports judge_ok and judge_bad  input  1 each  one-clk host verdict pulses.
REQ-010 SHALL have port showready  output  1  high in the first cycle of every ARMED entry, used to clear displays.
REQ-011 SHALL have port countdown  output  4  BCD seconds remaining in the active window.
REQ-012 SHALL have port winner  output  4  1..4 = current answering player; 0 = none.
REQ-013 SHALL have port excluded  output  4  per-player lockout mask for the current round.
REQ-014 SHALL have port score  output  16  four 4-bit BCD scores; [3:0] = player1.
REQ-015 SHALL have port state  output  3  FSM state code.

Function
REQ-016 SHALL implement states IDLE, ARMED, LOCKED and TIMEOUT.
REQ-017 In IDLE, on host_start, SHALL latch the player count as follows: values below 2 are clamped to 2 and values above 4 to 4.
REQ-018 In IDLE, on host_start, SHALL set excluded to the foul mask, i.e. the buzz bits high in that cycle.
REQ-019 In IDLE, on host_start, SHALL set excluded bits for players at or above the latched count.
REQ-020 In IDLE, on host_start, SHALL load countdown = T_ANSWER, clear winner and go to ARMED.
REQ-021 If all eligible players are fouled at start, SHALL go to TIMEOUT instead of ARMED.
REQ-022 Eligible players are those with index below the latched count and excluded bit low.
REQ-023 In ARMED, the valid buzz set SHALL be buzz AND NOT excluded.
REQ-024 In ARMED, the first cycle with a nonzero valid buzz set SHALL latch winner on the next edge and go to LOCKED.
REQ-025 On simultaneous valid buzzes, the lowest index SHALL win.
REQ-026 On the LOCKED entry edge, SHALL load countdown = T_REPLY.
REQ-027 In ARMED and LOCKED, each tick_1hz SHALL decrement countdown by 1.
REQ-028 A tick seen while countdown = 1 SHALL expire the window, and countdown SHALL show 0.
REQ-029 If a valid buzz and window expiry occur in the same cycle, the buzz SHALL take priority.
REQ-030 ARMED expiry SHALL go to TIMEOUT with winner = 0.
REQ-031 In LOCKED, judge_ok SHALL increment the winner's score (saturating at 9) and go to IDLE; winner SHALL hold until the next start.
REQ-032 In LOCKED, judge_bad or reply expiry SHALL set the winner's excluded bit and clear winner.
REQ-033 After that exclusion, if any eligible player remains, SHALL reload countdown = T_ANSWER and return to ARMED; otherwise SHALL go to TIMEOUT.
REQ-034 If judge_ok and judge_bad are both high, judge_bad SHALL be ignored; a judge pulse in the same cycle as reply expiry SHALL win over expiry.
REQ-035 In TIMEOUT, host_start SHALL go to IDLE, and SHALL NOT start a round in the same pulse.
REQ-036 Judge pulses outside LOCKED and host_start outside IDLE/TIMEOUT SHALL be ignored.
REQ-037 num_players changes SHALL take effect only at the next round start.
REQ-038 showready SHALL be a single-cycle pulse; all other outputs are registered.

Reset
REQ-039 While rst is low, SHALL hold state IDLE, countdown 0, winner 0, excluded 0, score 0 and showready 0.
REQ-040 Reset mid-round SHALL abandon the round, and no score change SHALL occur.

Structure
REQ-041 Package quiz_pkg SHALL hold the state encoding (IDLE=0, ARMED=1, LOCKED=2, TIMEOUT=3), the player code constants (NONE=0, P1..P4=1..4) and MAX_SCORE=9.
REQ-042 The design SHALL contain exactly one sub-module, quiz_bcd_downcnt: a loadable 4-bit BCD down-counter with tick enable and an expire flag.
REQ-043 The lowest-index priority select SHALL be inline in quiz_round_ctrl.

Verification
REQ-044 num=4, start, then buzz=0100 two cycles later -> ARMED then LOCKED, winner=3, countdown=5; judge_ok -> score[11:8]=1, IDLE.
REQ-045 num=3, simultaneous buzz=1110 -> winner=2; buzz=1000 -> ignored (player4 excluded).
REQ-046 buzz=0001 held during start -> excluded=0001 and player1 cannot win; buzz=0011 -> winner=2.
REQ-047 num=2, P1 wins then judge_bad, P2 wins then 5 ticks pass -> excluded=0011 and TIMEOUT, winner=0.
REQ-048 No buzz for 9 ticks -> countdown 9..0 then TIMEOUT; a buzz in the expiry cycle -> LOCKED instead.
REQ-049 Score 9 plus judge_ok -> stays 9; rst low in LOCKED -> all outputs return to reset values.
